fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the core register/PC block.
- Each cycle it reads the current `pc`, issues a read to a 1-cycle-latency instruction BRAM and drives `pcenable`/`next_pc` back to the core's PC register.
- A 2-entry buffer decouples BRAM returns from the decoder's valid/ready handshake.
- Branch/jump redirects from downstream flush the buffer and drop the in-flight read.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Each cycle the current core PC is presented to a 1-cycle-latency
// instruction BRAM. The returning word is parked in a 2-entry buffer that
// the decoder drains through a valid/ready handshake. Issue is throttled so
// that the buffer plus the in-flight read never exceed two words, which
// means a BRAM return always has a free slot. A redirect from downstream
// empties the buffer, drops the in-flight word and steers the core PC.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   pc                   current PC from the core PC register
//   pcenable, next_pc    load strobe / value for the core PC register
//   imem_en, imem_addr   BRAM read enable / word address (pc[IMEM_ADDR_W+1:2])
//   imem_rdata           BRAM data, valid one cycle after imem_en
//   redirect, redirect_pc taken branch/jump and its target
//   inst_valid, inst, inst_pc  buffer head towards the decoder
//   dec_ready            decoder accepts the head this cycle
module fetch_unit #(
    parameter int IMEM_ADDR_W = 15
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [31:0]            pc,
    output logic                   pcenable,
    output logic [31:0]            next_pc,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   inst_valid,
    output logic [31:0]            inst,
    output logic [31:0]            inst_pc,
    input  logic                   dec_ready
);

    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] buf_inst [2];
    logic [31:0] buf_pc   [2];

    logic        infl_p1;
    logic [31:0] infl_pc_p1;
    logic        kill_p1;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occ;

    // Occupancy after this cycle's pop, counting the word still in the BRAM.
    assign occ        = {1'b0, count} + {2'b00, infl_p1} - {2'b00, pop};
    assign inst_valid = (count != 2'd0) & ~redirect;
    assign pop        = inst_valid & dec_ready;
    // rstn gating keeps the BRAM and PC quiet while reset is held.
    assign issue      = rstn & ~redirect & (occ < 3'd2);
    assign push       = infl_p1 & ~redirect;

    assign imem_addr  = pc[IMEM_ADDR_W+1:2];
    // Buffer data is not reset; the head is masked to zero while empty.
    assign inst       = (count != 2'd0) ? buf_inst[rd_ptr] : 32'd0;
    assign inst_pc    = (count != 2'd0) ? buf_pc[rd_ptr]   : 32'd0;

    always_comb begin
        pcenable = 1'b0;
        imem_en  = 1'b0;
        next_pc  = pc + 32'd4;
        if (rstn && redirect) begin
            pcenable = 1'b1;
            next_pc  = redirect_pc;
        end else if (issue) begin
            pcenable = 1'b1;
            imem_en  = 1'b1;
        end
    end

    // ---- p0 -> p1: request issued, BRAM word returns next cycle ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            infl_p1 <= 1'b0;
            kill_p1 <= 1'b0;
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            infl_p1 <= issue;
            kill_p1 <= redirect;
            if (redirect) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // ---- p1 -> buffer: returning word written at the tail ----
    always_ff @(posedge clk) begin
        if (issue) infl_pc_p1 <= pc;
        if (push) begin
            buf_inst[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= infl_pc_p1;
        end
    end

    // A redirect suppresses issue in its own cycle, so the cycle after it
    // can never see an in-flight word from the old path.
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(push && (count == 2'd2) && !pop))
                else $error("fetch_unit: push into full buffer");
            assert (!(kill_p1 && infl_p1))
                else $error("fetch_unit: in-flight read in cycle after redirect");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models the core PC register and a BRAM whose word at
// address a is 0x1000 + a, then checks the delivered instruction stream
// against program order (sequential from the reset PC, restarting at each
// redirect target) plus the latencies of reset, redirect and stall.
module tb_fetch_unit;

    localparam int          AW       = 15;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk;
    logic          rstn;
    logic [31:0]   pc;
    logic          pcenable;
    logic [31:0]   next_pc;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          dec_ready;

    int            n_assert;
    int            n_fail;
    int            delivered;
    logic [31:0]   exp_pc;
    logic          got;

    fetch_unit #(.IMEM_ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .pc(pc), .pcenable(pcenable), .next_pc(next_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return 32'h1000 + {17'd0, a};
    endfunction

    // Core PC register.
    logic [31:0] core_pc;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         core_pc <= RESET_PC;
        else if (pcenable) core_pc <= next_pc;
    end
    assign pc = core_pc;

    // Instruction BRAM, one cycle read latency.
    initial imem_rdata = 32'd0;
    always_ff @(posedge clk) begin
        if (imem_en) imem_rdata <= word_of(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Program-order reference: the next instruction the decoder must receive.
    task automatic monitor();
        if (rstn) begin
            if (redirect) begin
                chk("redir_valid", {31'd0, inst_valid}, 32'd0);
                chk("redir_pcen", {31'd0, pcenable}, 32'd1);
                chk("redir_npc", next_pc, redirect_pc);
                chk("redir_imem_en", {31'd0, imem_en}, 32'd0);
                exp_pc = redirect_pc;
            end else if (inst_valid && dec_ready) begin
                chk("stream_pc", inst_pc, exp_pc);
                chk("stream_inst", inst, word_of(exp_pc[AW+1:2]));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
    endtask

    // Entered at posedge+1 or later; returns at the next posedge+1.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_imem_en"}, {31'd0, imem_en}, 32'd0);
        chk({tag, "_pcen"}, {31'd0, pcenable}, 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        delivered   = 0;
        exp_pc      = RESET_PC;
        rstn        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        dec_ready   = 1'b0;
        got         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // First cycle out of reset issues the reset PC.
        rstn = 1'b1;
        dec_ready = 1'b1;
        #1;
        chk("first_imem_en", {31'd0, imem_en}, 32'd1);
        chk("first_npc", next_pc, RESET_PC + 32'd4);
        chk("first_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        #1 chk("c1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        #1;
        chk("c2_valid", {31'd0, inst_valid}, 32'd1);
        chk("c2_inst_pc", inst_pc, 32'h0);
        chk("c2_inst", inst, 32'h1000);
        tick();

        // Streaming: one instruction per cycle.
        for (int i = 0; i < 8; i++) begin
            #1 chk("stream_valid", {31'd0, inst_valid}, 32'd1);
            tick();
        end

        // Backpressure: issue stops, head held.
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_pcen", {31'd0, pcenable}, 32'd0);
            chk("stall_imem_en", {31'd0, imem_en}, 32'd0);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_head", inst_pc, exp_pc);
            tick();
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 chk("release_valid", {31'd0, inst_valid}, 32'd1);
            tick();
        end

        // Redirect with a full buffer (an in-flight read cannot coexist
        // with two buffered words, so this is the fullest reachable state).
        dec_ready = 1'b0;
        repeat (3) tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        dec_ready = 1'b1;
        #1;
        chk("r_valid", {31'd0, inst_valid}, 32'd0);
        chk("r_npc", next_pc, 32'h200);
        tick();
        redirect = 1'b0;
        #1;
        chk("r1_addr", {17'd0, imem_addr}, 32'h80);
        chk("r1_imem_en", {31'd0, imem_en}, 32'd1);
        chk("r1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        #1 chk("r2_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        #1;
        chk("r3_valid", {31'd0, inst_valid}, 32'd1);
        chk("r3_inst_pc", inst_pc, 32'h200);
        chk("r3_inst", inst, 32'h1080);
        tick();
        repeat (4) tick();

        // Back-to-back redirects: only the second target survives.
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        #1;
        chk("bb_addr", {17'd0, imem_addr}, 32'hC0);
        chk("bb_imem_en", {31'd0, imem_en}, 32'd1);
        tick();
        #1 chk("bb1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        #1;
        chk("bb2_valid", {31'd0, inst_valid}, 32'd1);
        chk("bb2_inst_pc", inst_pc, 32'h300);
        tick();
        repeat (4) tick();

        // PC wrap at the top of the address space.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        chk("wrap_npc", next_pc, 32'h0);
        chk("wrap_addr", {17'd0, imem_addr}, 32'h7FFF);
        chk("wrap_imem_en", {31'd0, imem_en}, 32'd1);
        tick();
        tick();
        #1;
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", inst, 32'h8FFF);
        tick();
        #1;
        chk("wrap_next_inst_pc", inst_pc, 32'h0);
        chk("wrap_next_inst", inst, 32'h1000);
        tick();
        repeat (3) tick();

        // Asynchronous reset between edges, held across one edge.
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("areset");
        exp_pc = RESET_PC;
        @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        chk("ar_imem_en", {31'd0, imem_en}, 32'd1);
        chk("ar_addr", {17'd0, imem_addr}, 32'd0);
        chk("ar_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        #1 chk("ar1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        #1;
        chk("ar2_valid", {31'd0, inst_valid}, 32'd1);
        chk("ar2_inst_pc", inst_pc, RESET_PC);
        chk("ar2_inst", inst, 32'h1000);
        tick();

        // Random backpressure and redirects against the program-order model.
        for (int i = 0; i < 400; i++) begin
            dec_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        // Delivery must resume within the issue-to-valid latency.
        redirect  = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 if (inst_valid) got = 1'b1;
            tick();
        end
        chk("drain_valid", {31'd0, got}, 32'd1);
        chk("delivered_enough", {31'd0, (delivered > 200)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
